// File: rtl/key_pkg.sv
// +----------------------------------------------------------------------+
// | key_pkg                                                              |
// | Shared defaults and FSM state type for the key bank.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package key_pkg;

    localparam int KEY_W_DEF  = 16;
    localparam int SLOTS_DEF  = 4;
    localparam int ROUNDS_DEF = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/key_round_fn.sv
// +----------------------------------------------------------------------+
// | key_round_fn                                                         |
// | Round function: rotate p left by its own low bits, XOR round number. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_round_fn #(
    parameter int KEY_W = 16
) (
    input  logic [KEY_W-1:0] p,
    input  logic [KEY_W-1:0] r,
    output logic [KEY_W-1:0] next_key
);

    localparam int c_SH_W = $clog2(KEY_W);

    logic [c_SH_W-1:0]    w_amt;
    logic [2*KEY_W-1:0]   w_dbl;

    // Rotating the doubled word keeps amount 0 well-defined (no shift by KEY_W).
    assign w_amt    = p[c_SH_W-1:0];
    assign w_dbl    = {p, p} << w_amt;
    assign next_key = w_dbl[2*KEY_W-1:KEY_W] ^ r;

endmodule

`default_nettype wire

// File: rtl/key_bank.sv
// +----------------------------------------------------------------------+
// | key_bank                                                             |
// | Slotted key store that streams ROUNDS derived round keys per read.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_bank
    import key_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int SLOTS  = SLOTS_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(SLOTS)-1:0]  wr_slot,
    input  logic [KEY_W-1:0]          wr_key,
    input  logic                      clr_en,
    input  logic                      rd_req,
    input  logic [$clog2(SLOTS)-1:0]  rd_slot,
    input  logic                      key_ready,
    output logic [KEY_W-1:0]          key_out,
    output logic                      key_valid,
    output logic                      key_last,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      busy,
    output logic                      rd_err
);

    localparam int                c_RW         = $clog2(ROUNDS);
    localparam logic [c_RW-1:0]   c_LAST_ROUND = c_RW'(ROUNDS - 1);

    logic [KEY_W-1:0] r_keys [SLOTS];
    logic [SLOTS-1:0] r_valid;

    state_t           r_state;
    logic [KEY_W-1:0] r_work;
    logic [c_RW-1:0]  r_round;
    logic             r_key_valid;
    logic             r_key_last;
    logic             r_rd_err;

    logic [c_RW-1:0]  w_next_round;
    logic [KEY_W-1:0] w_next_key;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_keys[gi]  <= '0;
                    r_valid[gi] <= 1'b0;
                end else if (wr_en && (wr_slot == gi)) begin
                    r_keys[gi]  <= wr_key;
                    r_valid[gi] <= 1'b1;
                end else if (clr_en && (wr_slot == gi)) begin
                    r_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign w_next_round = r_round + 1'b1;

    key_round_fn #(
        .KEY_W (KEY_W)
    ) u_round_fn (
        .p        (r_work),
        .r        ({{(KEY_W-c_RW){1'b0}}, w_next_round}),
        .next_key (w_next_key)
    );

    // Loads sample the stored key before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_round     <= '0;
            r_key_valid <= 1'b0;
            r_key_last  <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            r_rd_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rd_req) begin
                        if (r_valid[rd_slot]) begin
                            r_work      <= r_keys[rd_slot];
                            r_round     <= '0;
                            r_key_valid <= 1'b1;
                            r_key_last  <= 1'b0;
                            r_state     <= ST_STREAM;
                        end else begin
                            r_rd_err    <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (r_key_valid && key_ready) begin
                        if (r_key_last) begin
                            r_key_valid <= 1'b0;
                            r_key_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_work      <= w_next_key;
                            r_round     <= w_next_round;
                            r_key_last  <= (w_next_round == c_LAST_ROUND);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign key_out   = r_work;
    assign key_valid = r_key_valid;
    assign key_last  = r_key_last;
    assign round_idx = r_round;
    assign busy      = (r_state == ST_STREAM);
    assign rd_err    = r_rd_err;

endmodule

`default_nettype wire
